// File: rtl/jk_stim_checker.sv
// jk_stim_checker: drives pseudo-random J/K vectors into a JK storage element,
// predicts its Q with an internal reference model and counts mismatches.
// Every output comes straight from a flop; q_in only reaches err_count/pass
// through registers.
module jk_stim_checker #(
    parameter int          N_VECTORS = 16,
    parameter int          SETTLE    = 1,
    parameter logic [7:0]  SEED      = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        q_in,
    output logic        j,
    output logic        k,
    output logic        dut_rst,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [15:0] vec_idx
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_DRIVE = 3'd2,
        S_WAIT  = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [15:0] LAST_IDX  = 16'(N_VECTORS - 1);
    localparam logic [15:0] WAIT_LAST = 16'(SETTLE - 1);

    // One Fibonacci step of x^8+x^6+x^5+x^4+1, shifting left into bit 0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Next Q of an ideal JK element for one applied J/K command.
    function automatic logic jk_model(input logic cur, input logic jv, input logic kv);
        logic nxt;
        case ({jv, kv})
            2'b00:   nxt = cur;
            2'b01:   nxt = 1'b0;
            2'b10:   nxt = 1'b1;
            2'b11:   nxt = ~cur;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    state_t      state_q, state_d;
    logic        j_q, j_d;
    logic        k_q, k_d;
    logic        dut_rst_q, dut_rst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [7:0]  err_count_q, err_count_d;
    logic [15:0] vec_idx_q, vec_idx_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        ref_q, ref_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [7:0]  lfsr_adv_s;
    logic [7:0]  err_inc_s;

    // Next-state and next-output computation for the run sequencer.
    always_comb begin
        state_d     = state_q;
        j_d         = j_q;
        k_d         = k_q;
        dut_rst_d   = dut_rst_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        vec_idx_d   = vec_idx_q;
        lfsr_d      = lfsr_q;
        ref_d       = ref_q;
        wait_cnt_d  = wait_cnt_q;
        lfsr_adv_s  = lfsr_step(lfsr_q);
        if ((q_in != ref_q) && (err_count_q != 8'd255)) begin
            err_inc_s = err_count_q + 8'd1;
        end else begin
            err_inc_s = err_count_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RST;
                    dut_rst_d   = 1'b1;
                    j_d         = 1'b0;
                    k_d         = 1'b0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_count_d = 8'd0;
                    vec_idx_d   = 16'd0;
                    lfsr_d      = SEED;
                    ref_d       = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_RST: begin
                // First vector comes straight from the seed.
                state_d   = S_DRIVE;
                dut_rst_d = 1'b0;
                j_d       = lfsr_q[1];
                k_d       = lfsr_q[0];
                ref_d     = jk_model(ref_q, lfsr_q[1], lfsr_q[0]);
            end
            S_DRIVE: begin
                state_d    = S_WAIT;
                wait_cnt_d = 16'd0;
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_CHECK;
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            S_CHECK: begin
                err_count_d = err_inc_s;
                lfsr_d      = lfsr_adv_s;
                if (vec_idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_inc_s == 8'd0);
                end else begin
                    state_d   = S_DRIVE;
                    vec_idx_d = vec_idx_q + 16'd1;
                    j_d       = lfsr_adv_s[1];
                    k_d       = lfsr_adv_s[0];
                    ref_d     = jk_model(ref_q, lfsr_adv_s[1], lfsr_adv_s[0]);
                end
            end
            default: begin
                state_d     = S_IDLE;
                j_d         = 1'b0;
                k_d         = 1'b0;
                dut_rst_d   = 1'b0;
                busy_d      = 1'b0;
                done_d      = 1'b0;
                pass_d      = 1'b0;
                err_count_d = 8'd0;
                vec_idx_d   = 16'd0;
                lfsr_d      = SEED;
                ref_d       = 1'b0;
                wait_cnt_d  = 16'd0;
            end
        endcase
    end

    // State and output registers; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            j_q         <= 1'b0;
            k_q         <= 1'b0;
            dut_rst_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= 8'd0;
            vec_idx_q   <= 16'd0;
            lfsr_q      <= SEED;
            ref_q       <= 1'b0;
            wait_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            j_q         <= j_d;
            k_q         <= k_d;
            dut_rst_q   <= dut_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            vec_idx_q   <= vec_idx_d;
            lfsr_q      <= lfsr_d;
            ref_q       <= ref_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign j         = j_q;
    assign k         = k_q;
    assign dut_rst   = dut_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_jk_stim_checker.sv
// Bench for jk_stim_checker: three instances (defaults, N_VECTORS=300,
// SETTLE=3), each facing a behavioural JK element whose Q can be passed
// through, tied low or inverted. A driver pushes the expected end-of-run
// result into a scoreboard queue; a monitor pops and compares on done.
module tb_jk_stim_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  start;
    logic [2:0]  q_in;
    logic [2:0]  j, k, dut_rst, busy, done, pass;
    logic [7:0]  err [3];
    logic [15:0] vidx [3];
    logic [1:0]  qmode [3];

    jk_stim_checker u_def (
        .clk(clk), .rst(rst), .start(start[0]), .q_in(q_in[0]),
        .j(j[0]), .k(k[0]), .dut_rst(dut_rst[0]), .busy(busy[0]),
        .done(done[0]), .pass(pass[0]), .err_count(err[0]), .vec_idx(vidx[0])
    );

    jk_stim_checker #(.N_VECTORS(300)) u_long (
        .clk(clk), .rst(rst), .start(start[1]), .q_in(q_in[1]),
        .j(j[1]), .k(k[1]), .dut_rst(dut_rst[1]), .busy(busy[1]),
        .done(done[1]), .pass(pass[1]), .err_count(err[1]), .vec_idx(vidx[1])
    );

    jk_stim_checker #(.SETTLE(3)) u_s3 (
        .clk(clk), .rst(rst), .start(start[2]), .q_in(q_in[2]),
        .j(j[2]), .k(k[2]), .dut_rst(dut_rst[2]), .busy(busy[2]),
        .done(done[2]), .pass(pass[2]), .err_count(err[2]), .vec_idx(vidx[2])
    );

    // Behavioural JK elements: act once per J/K command (a command is taken
    // only when the previous sampled J/K was idle 00), reset by dut_rst.
    for (genvar g = 0; g < 3; g++) begin : g_jk
        logic       qm   = 1'b0;
        logic [1:0] prev = 2'b00;
        always @(posedge clk) begin
            if (dut_rst[g]) begin
                qm <= 1'b0;
            end else if (prev == 2'b00) begin
                case ({j[g], k[g]})
                    2'b01:   qm <= 1'b0;
                    2'b10:   qm <= 1'b1;
                    2'b11:   qm <= ~qm;
                    default: qm <= qm;
                endcase
            end
            prev <= {j[g], k[g]};
        end
        assign q_in[g] = (qmode[g] == 2'd0) ? qm :
                         (qmode[g] == 2'd1) ? 1'b0 : ~qm;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc [3];

    typedef struct {
        int inst;
        int err;
        int pass;
        int lat;
        int last_idx;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic [2:0] done_prev = 3'b000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Independent reference: error count a run should report for a Q mode.
    function automatic int model_errs(input logic [7:0] seed, input int n, input int mode);
        logic [7:0] l = seed;
        logic       e = 1'b0;
        logic       obs;
        int         errs = 0;
        for (int v = 0; v < n; v++) begin
            case (l[1:0])
                2'b01:   e = 1'b0;
                2'b10:   e = 1'b1;
                2'b11:   e = ~e;
                default: e = e;
            endcase
            obs = (mode == 0) ? e : (mode == 1) ? 1'b0 : ~e;
            if (obs != e) errs++;
            l = {l[6:0], ^(l & 8'hB8)};
        end
        return (errs > 255) ? 255 : errs;
    endfunction

    // Monitor: on each rising done, pop the expected result and compare.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done[i] && !done_prev[i]) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", i, -1);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("done_inst", i, mon_e.inst);
                    chk("err_count", int'(err[i]), mon_e.err);
                    chk("pass", int'(pass[i]), mon_e.pass);
                    chk("run_length", cyc - start_cyc[i], mon_e.lat);
                    chk("vec_idx_last", int'(vidx[i]), mon_e.last_idx);
                    chk("busy_low_at_done", int'(busy[i]), 0);
                end
            end
        end
        done_prev = done;
    end

    task automatic start_run(input int i, input bit push, input int exp_err,
                             input int lat, input int nvec);
        exp_t e;
        @(negedge clk);
        start[i] = 1'b1;
        if (push) begin
            e.inst = i; e.err = exp_err; e.pass = (exp_err == 0) ? 1 : 0;
            e.lat = lat; e.last_idx = nvec - 1;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start[i] = 1'b0;
        start_cyc[i] = cyc;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drain", sb_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start = 3'b000;
        for (int i = 0; i < 3; i++) qmode[i] = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", int'({j[0], k[0], dut_rst[0], busy[0], done[0],
                                   pass[0], err[0], vidx[0]}), 0);
        rst = 1'b0;

        // Correct DUT, defaults: dut_rst pulse then pass after 49 cycles.
        start_run(0, 1'b1, 0, 49, 16);
        chk("dut_rst_high", int'(dut_rst[0]), 1);
        chk("busy_high", int'(busy[0]), 1);
        @(posedge clk);
        #1;
        chk("dut_rst_one_cycle", int'(dut_rst[0]), 0);
        drain();

        // Q tied low: errors on every vector where the model predicts 1.
        qmode[0] = 2'd1;
        start_run(0, 1'b1, model_errs(8'hA5, 16, 1), 49, 16);
        drain();
        chk("tied0_err_nonzero", int'(err[0] != 8'd0), 1);

        // Restart from DONE clears status; start while busy is ignored.
        qmode[0] = 2'd0;
        start_run(0, 1'b1, 0, 49, 16);
        chk("restart_status", int'({busy[0], done[0], pass[0], err[0]}), 11'h400);
        repeat (5) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        drain();

        // rst during WAIT returns everything to reset values.
        start_run(0, 1'b0, 0, 0, 16);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrun_reset_outputs", int'({j[0], k[0], dut_rst[0], busy[0], done[0],
                                         pass[0], err[0], vidx[0]}), 0);
        rst = 1'b0;
        start_run(0, 1'b1, 0, 49, 16);
        drain();

        // Inverting DUT over 300 vectors: count saturates at 255.
        qmode[1] = 2'd2;
        start_run(1, 1'b1, 255, 901, 300);
        drain();

        // SETTLE=3: first vector (seed A5 -> J=0,K=1) held 4 cycles, then idle.
        start_run(2, 1'b1, 0, 81, 16);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk("s3_jk_held", int'({j[2], k[2]}), 1);
        end
        @(posedge clk);
        #1;
        chk("s3_jk_released", int'({j[2], k[2]}), 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
